fetch_queue_2w: RTL and testbench
=================================

# fetch_queue_2w

Two-wide instruction fetch queue between IF and ID, a parametrised successor of the single-push IFID queue. IF pushes 0, 1 or 2 instruction words per cycle, each tagged with its fetch address; ID sees the two oldest entries show-ahead and pops 0, 1 or 2 per cycle. The queue supports pipeline freeze on cache miss, single-cycle flush on taken branch, and registered occupancy and error reporting.

## Interface
Parameters:
- DATA_WIDTH, 32, bits per instruction word
- TAG_WIDTH, 32, bits per fetch-address tag
- ADDR_WIDTH, 4, depth = 2^ADDR_WIDTH entries; legal range 2..8
- SHOW_DEBUG, 0, when 1 the model prints push, pop and flush events in simulation only

Ports:
- CLK  in  1  clock; every register samples on the rising edge
- RESET  in  1  asynchronous, active-low reset
- FREEZE  in  1  when high, holds all state; push and pop are ignored
- flush  in  1  empties the queue
- push_cnt  in  2  number of words to push: 0, 1 or 2; 3 is illegal
- push_data0, push_data1  in  DATA_WIDTH  words in program order; data0 is the older
- push_tag0, push_tag1  in  TAG_WIDTH  fetch address of each word
- pop_cnt  in  2  number of words to pop: 0, 1 or 2; 3 is illegal
- head_data0, head_data1  out  DATA_WIDTH  oldest and second-oldest entry
- head_tag0, head_tag1  out  TAG_WIDTH  tags of the head entries
- head_valid0, head_valid1  out  1  head entry present
- count  out  ADDR_WIDTH+1  current occupancy
- full  out  1  count == DEPTH
- almost_full  out  1  free space < 2
- empty  out  1  count == 0
- overflow_err, underflow_err  out  1  one-cycle registered error pulses

## Operation
- State: storage array, wr_ptr and rd_ptr (ADDR_WIDTH bits, modulo-DEPTH wrap), count register.
- Storage is not reset. Pointers, count and error flags reset to 0.
- Head outputs are combinational reads of storage:
  - head_data0 reads rd_ptr; head_data1 reads rd_ptr+1 (mod DEPTH).
  - head_valid0 = count ≥ 1; head_valid1 = count ≥ 2.
  - Invalid head data and tag outputs are forced to 0.
- Priority per cycle, highest first:
  1. RESET low: reset all registered state.
  2. flush: rd_ptr ← wr_ptr, count ← 0; push and pop are ignored; error flags ← 0.
  3. FREEZE: hold all state; error flags ← 0.
  4. Normal operation, below.
- Push:
  - Accepted only if push_cnt ≤ free space, where free = DEPTH − pre-edge count. Same-cycle pops do not make room.
  - A rejected push writes nothing (no partial push) and sets overflow_err for one cycle.
  - An accepted push writes data0/tag0 at wr_ptr and data1/tag1 at wr_ptr+1, then wr_ptr += push_cnt.
- Pop:
  - eff_pop = min(pop_cnt, pre-edge count); rd_ptr += eff_pop.
  - If pop_cnt > pre-edge count, underflow_err is set for one cycle.
  - Pop applies to the pre-edge contents, so a word pushed in the same cycle cannot be popped in that cycle.
- count ← count + accepted_push − eff_pop.
- push_cnt = 3 or pop_cnt = 3 is treated as 0 and raises the matching error flag.

## Timing
- Push-to-visible latency is 1 cycle: a word written on edge N appears on head_* after edge N.
- Pop takes effect on the edge; the next entries appear on head_* after that edge.
- count, full, almost_full and empty are derived from registered count and are valid the cycle after each edge.
- Full queue with pop 2 and push 2 in the same cycle: the push is rejected because of the pre-edge free-space rule. IF must use almost_full.
- Reset mid-operation clears the queue immediately and asynchronously. Head outputs go to 0 and valids to 0 while RESET is low.
- Pointer wrap from DEPTH−1 to 0 is seamless, including a 2-word push or pop that straddles the wrap.

## Structure
- Shared package fetch_queue_pkg:
  - Constants: DEPTH function of ADDR_WIDTH, MAX_LANES = 2.
  - Typedef fq_entry_t holding {tag, data}.
- Sub-module fetch_queue_ram: DEPTH × (TAG_WIDTH+DATA_WIDTH) register file with 2 write ports and 2 asynchronous read ports, and no reset.
- Pointer, count and error logic live in fetch_queue_2w.

## Test plan
- Reset, then push 2 words (0xA/0x100, 0xB/0x104) -> next cycle count = 2, head_data0 = 0xA, head_data1 = 0xB, head_tag1 = 0x104.
- DEPTH = 16. Push 2 per cycle for 8 cycles -> full = 1. A 9th push of 1 word -> overflow_err pulse, count stays 16, contents unchanged.
- count = 1, pop_cnt = 2 -> count = 0, underflow_err pulse, empty = 1.
- count = 5, flush with simultaneous push 2 and pop 1 -> count = 0, empty = 1, no errors.
- FREEZE high for 3 cycles with push 2 and pop 2 asserted -> count, pointers and heads unchanged. After release, normal operation resumes.
- Fill to 15, pop 2, push 2 so the writes straddle index 15→0. Drain the queue -> words return in exact push order. Assert RESET low mid-drain -> all valids drop immediately.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the two-wide IF->ID fetch queue.
// Depth helper, lane count and the stored entry layout.
package fetch_queue_pkg;

    localparam int MAX_LANES = 2;
    localparam int FQ_DATA_W = 32;
    localparam int FQ_TAG_W  = 32;

    typedef struct packed {
        logic [FQ_TAG_W-1:0]  tag;
        logic [FQ_DATA_W-1:0] data;
    } fq_entry_t;

    function automatic int fq_depth(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/fetch_queue_ram.sv
// Fetch queue storage: DEPTH x EW register file, no reset.
// Ports: CLK; we0/we1 + waddr/wdata write ports; raddr0/1 -> rdata0/1 async.
module fetch_queue_ram
    import fetch_queue_pkg::*;
#(
    parameter int EW         = 64,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  CLK,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] waddr0,
    input  logic [ADDR_WIDTH-1:0] waddr1,
    input  logic [EW-1:0]         wdata0,
    input  logic [EW-1:0]         wdata1,
    input  logic [ADDR_WIDTH-1:0] raddr0,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    output logic [EW-1:0]         rdata0,
    output logic [EW-1:0]         rdata1
);

    localparam int DEPTH = fq_depth(ADDR_WIDTH);

    logic [EW-1:0] mem_q [DEPTH];

    // The two write addresses are always consecutive, so never equal.
    always_ff @(posedge CLK) begin
        if (we0) mem_q[waddr0] <= wdata0;
        if (we1) mem_q[waddr1] <= wdata1;
    end

    assign rdata0 = mem_q[raddr0];
    assign rdata1 = mem_q[raddr1];

endmodule

// File: rtl/fetch_queue_2w.sv
// Two-wide fetch queue: push 0..2 words from IF, pop 0..2 show-ahead to ID.
// Ports: CLK/RESET/FREEZE/flush, push_*, pop_cnt, head_*, count/flags, errors.
module fetch_queue_2w
    import fetch_queue_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int SHOW_DEBUG = 0
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  FREEZE,
    input  logic                  flush,
    input  logic [1:0]            push_cnt,
    input  logic [DATA_WIDTH-1:0] push_data0,
    input  logic [DATA_WIDTH-1:0] push_data1,
    input  logic [TAG_WIDTH-1:0]  push_tag0,
    input  logic [TAG_WIDTH-1:0]  push_tag1,
    input  logic [1:0]            pop_cnt,
    output logic [DATA_WIDTH-1:0] head_data0,
    output logic [DATA_WIDTH-1:0] head_data1,
    output logic [TAG_WIDTH-1:0]  head_tag0,
    output logic [TAG_WIDTH-1:0]  head_tag1,
    output logic                  head_valid0,
    output logic                  head_valid1,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  almost_full,
    output logic                  empty,
    output logic                  overflow_err,
    output logic                  underflow_err
);

    localparam int EW    = TAG_WIDTH + DATA_WIDTH;
    localparam int DEPTH = fq_depth(ADDR_WIDTH);

    typedef logic [ADDR_WIDTH-1:0] ptr_t;
    typedef logic [ADDR_WIDTH:0]   cnt_t;

    localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

    // Event tracing is a feature of the behavioural model only.
    if (SHOW_DEBUG != 0) begin : g_dbg
    end

    ptr_t wr_q, wr_d;
    ptr_t rd_q, rd_d;
    cnt_t cnt_q, cnt_d;
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    logic    we0, we1;
    logic [EW-1:0] rdata0, rdata1;

    cnt_t free_w;
    logic push_ill, pop_ill;
    cnt_t push_n, pop_n, eff_pop;
    logic push_ok, pop_short;

    // Room is judged on pre-edge occupancy; same-cycle pops free nothing.
    assign free_w    = DEPTH_C - cnt_q;
    assign push_ill  = push_cnt > 2'(MAX_LANES);
    assign pop_ill   = pop_cnt > 2'(MAX_LANES);
    assign push_n    = push_ill ? '0 : cnt_t'(push_cnt);
    assign pop_n     = pop_ill ? '0 : cnt_t'(pop_cnt);
    assign push_ok   = push_n <= free_w;
    assign pop_short = pop_n > cnt_q;
    assign eff_pop   = pop_short ? cnt_q : pop_n;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        we0   = 1'b0;
        we1   = 1'b0;
        if (flush) begin
            rd_d  = wr_q;
            cnt_d = '0;
        end else if (!FREEZE) begin
            if (push_ok) begin
                we0  = push_n >= cnt_t'(1);
                we1  = push_n == cnt_t'(2);
                wr_d = wr_q + ptr_t'(push_n);
            end
            ovf_d = push_ill | !push_ok;
            unf_d = pop_ill | pop_short;
            rd_d  = rd_q + ptr_t'(eff_pop);
            cnt_d = cnt_q + (push_ok ? push_n : '0) - eff_pop;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    fetch_queue_ram #(
        .EW         (EW),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .CLK    (CLK),
        .we0    (we0),
        .we1    (we1),
        .waddr0 (wr_q),
        .waddr1 (wr_q + ptr_t'(1)),
        .wdata0 ({push_tag0, push_data0}),
        .wdata1 ({push_tag1, push_data1}),
        .raddr0 (rd_q),
        .raddr1 (rd_q + ptr_t'(1)),
        .rdata0 (rdata0),
        .rdata1 (rdata1)
    );

    assign head_valid0 = cnt_q != '0;
    assign head_valid1 = cnt_q > cnt_t'(1);

    // Unoccupied slots hold stale or unreset data; never expose it.
    assign head_data0 = head_valid0 ? rdata0[DATA_WIDTH-1:0] : '0;
    assign head_tag0  = head_valid0 ? rdata0[EW-1:DATA_WIDTH] : '0;
    assign head_data1 = head_valid1 ? rdata1[DATA_WIDTH-1:0] : '0;
    assign head_tag1  = head_valid1 ? rdata1[EW-1:DATA_WIDTH] : '0;

    assign count         = cnt_q;
    assign full          = cnt_q == DEPTH_C;
    assign almost_full   = free_w < cnt_t'(2);
    assign empty         = cnt_q == '0;
    assign overflow_err  = ovf_q;
    assign underflow_err = unf_q;

endmodule

// File: tb/tb_fetch_queue_2w.sv
// Directed bench for fetch_queue_2w: vector table plus corner sequences.
// Covers overflow, underflow, freeze, flush, pointer wrap and async reset.
module tb_fetch_queue_2w;
    import fetch_queue_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        FREEZE = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  push_cnt = '0;
    logic [31:0] push_data0 = '0, push_data1 = '0;
    logic [31:0] push_tag0 = '0, push_tag1 = '0;
    logic [1:0]  pop_cnt = '0;
    logic [31:0] head_data0, head_data1, head_tag0, head_tag1;
    logic        head_valid0, head_valid1;
    logic [4:0]  count;
    logic        full, almost_full, empty;
    logic        overflow_err, underflow_err;

    int n_chk = 0;
    int n_err = 0;

    fetch_queue_2w #(
        .DATA_WIDTH (32),
        .TAG_WIDTH  (32),
        .ADDR_WIDTH (4),
        .SHOW_DEBUG (0)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .FREEZE        (FREEZE),
        .flush         (flush),
        .push_cnt      (push_cnt),
        .push_data0    (push_data0),
        .push_data1    (push_data1),
        .push_tag0     (push_tag0),
        .push_tag1     (push_tag1),
        .pop_cnt       (pop_cnt),
        .head_data0    (head_data0),
        .head_data1    (head_data1),
        .head_tag0     (head_tag0),
        .head_tag1     (head_tag1),
        .head_valid0   (head_valid0),
        .head_valid1   (head_valid1),
        .count         (count),
        .full          (full),
        .almost_full   (almost_full),
        .empty         (empty),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]  pc;
        logic [31:0] d0, t0, d1, t1;
        logic [1:0]  oc;
        logic        fl, fz;
        logic [4:0]  e_cnt;
        logic [31:0] e_h0, e_t0, e_h1, e_t1;
        logic        e_v0, e_v1, e_ovf, e_unf, e_emp;
    } vec_t;

    vec_t vt [10];
    fq_entry_t exp_q [$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic [1:0] pc, input logic [31:0] d0,
                        input logic [31:0] t0, input logic [31:0] d1,
                        input logic [31:0] t1, input logic [1:0] oc,
                        input logic fl, input logic fz);
        push_cnt   = pc;
        push_data0 = d0;
        push_tag0  = t0;
        push_data1 = d1;
        push_tag1  = t1;
        pop_cnt    = oc;
        flush      = fl;
        FREEZE     = fz;
        @(posedge CLK);
        #1;
        push_cnt = '0;
        pop_cnt  = '0;
        flush    = 1'b0;
        FREEZE   = 1'b0;
    endtask

    task automatic chk_heads(input string nm);
        chk({nm, "_cnt"}, 64'(count), 64'(exp_q.size()));
        if (exp_q.size() >= 1) begin
            chk({nm, "_h0"}, 64'(head_data0), 64'(exp_q[0].data));
            chk({nm, "_t0"}, 64'(head_tag0), 64'(exp_q[0].tag));
        end else begin
            chk({nm, "_v0"}, 64'(head_valid0), 64'(0));
        end
        if (exp_q.size() >= 2) begin
            chk({nm, "_h1"}, 64'(head_data1), 64'(exp_q[1].data));
            chk({nm, "_t1"}, 64'(head_tag1), 64'(exp_q[1].tag));
        end else begin
            chk({nm, "_v1"}, 64'(head_valid1), 64'(0));
        end
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        exp_q.delete();
    endtask

    initial begin
        int k;
        fq_entry_t e0, e1;

        vt[0] = '{2'd2, 32'hA, 32'h100, 32'hB, 32'h104, 2'd0, 0, 0,
                  5'd2, 32'hA, 32'h100, 32'hB, 32'h104, 1, 1, 0, 0, 0};
        vt[1] = '{2'd0, 0, 0, 0, 0, 2'd1, 0, 0,
                  5'd1, 32'hB, 32'h104, 0, 0, 1, 0, 0, 0, 0};
        vt[2] = '{2'd0, 0, 0, 0, 0, 2'd2, 0, 0,
                  5'd0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
        vt[3] = '{2'd0, 0, 0, 0, 0, 2'd0, 0, 0,
                  5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        vt[4] = '{2'd3, 32'hF, 32'h200, 32'hF, 32'h204, 2'd0, 0, 0,
                  5'd0, 0, 0, 0, 0, 0, 0, 1, 0, 1};
        vt[5] = '{2'd0, 0, 0, 0, 0, 2'd3, 0, 0,
                  5'd0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
        vt[6] = '{2'd1, 32'hC, 32'h108, 0, 0, 2'd1, 0, 0,
                  5'd1, 32'hC, 32'h108, 0, 0, 1, 0, 0, 1, 0};
        vt[7] = '{2'd2, 32'hD, 32'h10C, 32'hE, 32'h110, 2'd1, 0, 0,
                  5'd2, 32'hD, 32'h10C, 32'hE, 32'h110, 1, 1, 0, 0, 0};
        vt[8] = '{2'd2, 32'h1, 32'h1, 32'h2, 32'h2, 2'd2, 0, 1,
                  5'd2, 32'hD, 32'h10C, 32'hE, 32'h110, 1, 1, 0, 0, 0};
        vt[9] = '{2'd1, 32'h3, 32'h3, 0, 0, 2'd0, 1, 0,
                  5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        chk("rst_cnt", 64'(count), 64'(0));
        chk("rst_empty", 64'(empty), 64'(1));
        chk("rst_full", 64'(full), 64'(0));
        chk("rst_af", 64'(almost_full), 64'(0));
        chk("rst_v0", 64'(head_valid0), 64'(0));
        chk("rst_ovf", 64'(overflow_err), 64'(0));
        chk("rst_unf", 64'(underflow_err), 64'(0));

        for (int i = 0; i < 10; i++) begin
            step(vt[i].pc, vt[i].d0, vt[i].t0, vt[i].d1, vt[i].t1,
                 vt[i].oc, vt[i].fl, vt[i].fz);
            chk($sformatf("v%0d_cnt", i), 64'(count), 64'(vt[i].e_cnt));
            chk($sformatf("v%0d_h0", i), 64'(head_data0), 64'(vt[i].e_h0));
            chk($sformatf("v%0d_t0", i), 64'(head_tag0), 64'(vt[i].e_t0));
            chk($sformatf("v%0d_h1", i), 64'(head_data1), 64'(vt[i].e_h1));
            chk($sformatf("v%0d_t1", i), 64'(head_tag1), 64'(vt[i].e_t1));
            chk($sformatf("v%0d_v0", i), 64'(head_valid0), 64'(vt[i].e_v0));
            chk($sformatf("v%0d_v1", i), 64'(head_valid1), 64'(vt[i].e_v1));
            chk($sformatf("v%0d_ovf", i), 64'(overflow_err),
                64'(vt[i].e_ovf));
            chk($sformatf("v%0d_unf", i), 64'(underflow_err),
                64'(vt[i].e_unf));
            chk($sformatf("v%0d_emp", i), 64'(empty), 64'(vt[i].e_emp));
        end

        // Fill to full, then overflow with a single word.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            e0 = '{tag: 32'h2000 + 32'(8 * i), data: 32'h1000 + 32'(2 * i)};
            e1 = '{tag: 32'h2004 + 32'(8 * i), data: 32'h1001 + 32'(2 * i)};
            step(2'd2, e0.data, e0.tag, e1.data, e1.tag, 2'd0, 0, 0);
            exp_q.push_back(e0);
            exp_q.push_back(e1);
        end
        chk("fill_full", 64'(full), 64'(1));
        chk("fill_af", 64'(almost_full), 64'(1));
        chk_heads("fill");
        step(2'd1, 32'hDEAD, 32'hBEEF, 0, 0, 2'd0, 0, 0);
        chk("ovf1_err", 64'(overflow_err), 64'(1));
        chk_heads("ovf1");
        step(2'd0, 0, 0, 0, 0, 2'd0, 0, 0);
        chk("ovf1_pulse", 64'(overflow_err), 64'(0));

        // Freeze holds everything even with push/pop requested.
        for (int i = 0; i < 3; i++) begin
            step(2'd2, 32'h55, 32'h55, 32'h66, 32'h66, 2'd2, 0, 1);
            chk_heads($sformatf("frz%0d", i));
            chk($sformatf("frz%0d_ovf", i), 64'(overflow_err), 64'(0));
            chk($sformatf("frz%0d_unf", i), 64'(underflow_err), 64'(0));
        end

        // Full with pop 2 + push 2: push rejected on pre-edge room.
        step(2'd2, 32'h77, 32'h77, 32'h88, 32'h88, 2'd2, 0, 0);
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        chk("fp2_ovf", 64'(overflow_err), 64'(1));
        chk("fp2_unf", 64'(underflow_err), 64'(0));
        chk("fp2_af", 64'(almost_full), 64'(0));
        chk_heads("fp2");

        // Drain to 5, then flush against push 2 + pop 1.
        for (int i = 0; i < 4; i++) begin
            step(2'd0, 0, 0, 0, 0, 2'd2, 0, 0);
            void'(exp_q.pop_front());
            void'(exp_q.pop_front());
        end
        step(2'd0, 0, 0, 0, 0, 2'd1, 0, 0);
        void'(exp_q.pop_front());
        chk_heads("pre_fl");
        step(2'd2, 32'h99, 32'h99, 32'h9A, 32'h9A, 2'd1, 1, 0);
        exp_q.delete();
        chk("fl_cnt", 64'(count), 64'(0));
        chk("fl_empty", 64'(empty), 64'(1));
        chk("fl_ovf", 64'(overflow_err), 64'(0));
        chk("fl_unf", 64'(underflow_err), 64'(0));

        // Wrap: fill to 15, pop 2, push 2 across index 15 -> 0.
        k = 0;
        for (int i = 0; i < 7; i++) begin
            e0 = '{tag: 32'h4000 + 32'(4 * k), data: 32'h3000 + 32'(k)};
            e1 = '{tag: 32'h4004 + 32'(4 * k), data: 32'h3001 + 32'(k)};
            step(2'd2, e0.data, e0.tag, e1.data, e1.tag, 2'd0, 0, 0);
            exp_q.push_back(e0);
            exp_q.push_back(e1);
            k += 2;
        end
        e0 = '{tag: 32'h4000 + 32'(4 * k), data: 32'h3000 + 32'(k)};
        step(2'd1, e0.data, e0.tag, 0, 0, 2'd0, 0, 0);
        exp_q.push_back(e0);
        k++;
        chk_heads("w15");
        step(2'd0, 0, 0, 0, 0, 2'd2, 0, 0);
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        e0 = '{tag: 32'h4000 + 32'(4 * k), data: 32'h3000 + 32'(k)};
        e1 = '{tag: 32'h4004 + 32'(4 * k), data: 32'h3001 + 32'(k)};
        step(2'd2, e0.data, e0.tag, e1.data, e1.tag, 2'd0, 0, 0);
        exp_q.push_back(e0);
        exp_q.push_back(e1);
        k += 2;
        chk_heads("wstr");
        e0 = '{tag: 32'h4000 + 32'(4 * k), data: 32'h3000 + 32'(k)};
        step(2'd1, e0.data, e0.tag, 0, 0, 2'd0, 0, 0);
        exp_q.push_back(e0);
        chk("w16_full", 64'(full), 64'(1));

        step(2'd0, 0, 0, 0, 0, 2'd1, 0, 0);
        void'(exp_q.pop_front());
        chk_heads("dr0");
        for (int i = 0; i < 7; i++) begin
            step(2'd0, 0, 0, 0, 0, 2'd2, 0, 0);
            void'(exp_q.pop_front());
            void'(exp_q.pop_front());
            chk_heads($sformatf("dr%0d", i + 1));
        end

        // Asynchronous reset mid-drain drops valids without a clock edge.
        #2;
        RESET = 1'b0;
        #1;
        chk("arst_v0", 64'(head_valid0), 64'(0));
        chk("arst_v1", 64'(head_valid1), 64'(0));
        chk("arst_cnt", 64'(count), 64'(0));
        chk("arst_h0", 64'(head_data0), 64'(0));
        chk("arst_empty", 64'(empty), 64'(1));
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
